hazard_stall_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage MIPS core.
- Sits alongside the ID/EX operand-forwarding unit. Forwarding cannot cover load-use or branch hazards, so this block covers them: it inserts load-use bubbles, flushes IF/ID on taken branches, and freezes the whole pipeline while data memory is busy.
- Keeps stall/flush performance counters and a sticky memory-timeout error.

---
 rtl/hazard_stall_ctrl.sv | 143 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl
// Brief    : Pipeline sequencing controller for the 5-stage MIPS core.
//            Inserts load-use bubbles, flushes IF/ID on taken branches and
//            freezes the pipeline while data memory is busy. Keeps saturating
//            stall/flush counters and a sticky memory-timeout error.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IfIdRs,
    input  logic [4:0]       IfIdRt,
    input  logic             IfIdUsesRt,
    input  logic             IdExMemRead,
    input  logic [4:0]       IdExRt,
    input  logic             BranchTaken,
    input  logic             DMemBusy,
    output logic             PcWrite,
    output logic             IfIdWrite,
    output logic             IdExBubble,
    output logic             IfIdFlush,
    output logic             PipeFreeze,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount,
    output logic             MemTimeout
);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_FREEZE = 2'd1;
    localparam logic [1:0] S_ERROR  = 2'd2;

    localparam logic [7:0] C_MAX_WAIT = 8'(MAX_WAIT);

    logic [1:0]       r_state;
    logic [1:0]       w_stateNext;
    logic [7:0]       r_waitCnt;
    logic [7:0]       w_waitNext;
    logic             w_loadUse;
    logic             w_stallInc;
    logic             w_flushInc;
    logic             w_timeoutSet;
    logic [CNT_W-1:0] r_stallCount;
    logic [CNT_W-1:0] r_flushCount;
    logic             r_memTimeout;

    // Load-use hazard: the load's destination feeds a source of the ID instruction
    assign w_loadUse = IdExMemRead && (IdExRt != 5'd0) &&
                       ((IdExRt == IfIdRs) || (IfIdUsesRt && (IdExRt == IfIdRt)));

    // Priority resolution: enables, next state, wait counter and counter events
    always_comb begin
        PcWrite      = 1'b1;
        IfIdWrite    = 1'b1;
        IdExBubble   = 1'b0;
        IfIdFlush    = 1'b0;
        PipeFreeze   = 1'b0;
        w_stateNext  = r_state;
        w_waitNext   = r_waitCnt;
        w_stallInc   = 1'b0;
        w_flushInc   = 1'b0;
        w_timeoutSet = 1'b0;

        if (rst) begin
            // Held reset: PC and IF/ID closed, a nop sits in both ID/EX and IF/ID
            PcWrite    = 1'b0;
            IfIdWrite  = 1'b0;
            IdExBubble = 1'b1;
            IfIdFlush  = 1'b1;
        end else if (r_state == S_ERROR || r_state == 2'd3) begin
            // Error is terminal until reset; the unused encoding behaves the same
            PcWrite     = 1'b0;
            IfIdWrite   = 1'b0;
            PipeFreeze  = 1'b1;
            w_stateNext = S_ERROR;
        end else if (DMemBusy) begin
            // Memory wait overrides branch and load-use; both re-evaluate afterwards
            PcWrite    = 1'b0;
            IfIdWrite  = 1'b0;
            PipeFreeze = 1'b1;
            w_stallInc = 1'b1;
            if (r_state == S_RUN) begin
                w_stateNext = S_FREEZE;
                w_waitNext  = 8'd1;
            end else if (r_waitCnt < C_MAX_WAIT) begin
                w_waitNext = r_waitCnt + 8'd1;
            end else begin
                w_stateNext  = S_ERROR;
                w_timeoutSet = 1'b1;
            end
        end else begin
            w_stateNext = S_RUN;
            w_waitNext  = 8'd0;
            if (w_loadUse) begin
                // Bubble wins over a branch; the branch re-resolves next cycle
                PcWrite    = 1'b0;
                IfIdWrite  = 1'b0;
                IdExBubble = 1'b1;
                w_stallInc = 1'b1;
            end else if (BranchTaken) begin
                IfIdFlush  = 1'b1;
                w_flushInc = 1'b1;
            end
        end
    end

    // State and wait counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_RUN;
            r_waitCnt <= 8'd0;
        end else begin
            r_state   <= w_stateNext;
            r_waitCnt <= w_waitNext;
        end
    end

    // Saturating performance counters and the sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stallCount <= '0;
            r_flushCount <= '0;
            r_memTimeout <= 1'b0;
        end else begin
            if (w_stallInc && (r_stallCount != {CNT_W{1'b1}}))
                r_stallCount <= r_stallCount + 1'b1;
            if (w_flushInc && (r_flushCount != {CNT_W{1'b1}}))
                r_flushCount <= r_flushCount + 1'b1;
            if (w_timeoutSet)
                r_memTimeout <= 1'b1;
        end
    end

    assign StallCount = r_stallCount;
    assign FlushCount = r_flushCount;
    assign MemTimeout = r_memTimeout;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_ctrl
// Brief    : Directed self-checking bench for hazard_stall_ctrl
//            (MAX_WAIT=4, CNT_W=4 so timeout and saturation are reachable).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 4;

    // Enable vector order: {PcWrite, IfIdWrite, IdExBubble, IfIdFlush, PipeFreeze}
    localparam logic [4:0] C_RESET  = 5'b00110;
    localparam logic [4:0] C_NORMAL = 5'b11000;
    localparam logic [4:0] C_BUBBLE = 5'b00100;
    localparam logic [4:0] C_FLUSH  = 5'b11010;
    localparam logic [4:0] C_FREEZE = 5'b00001;

    logic             clk;
    logic             rst;
    logic [4:0]       IfIdRs;
    logic [4:0]       IfIdRt;
    logic             IfIdUsesRt;
    logic             IdExMemRead;
    logic [4:0]       IdExRt;
    logic             BranchTaken;
    logic             DMemBusy;
    logic             PcWrite;
    logic             IfIdWrite;
    logic             IdExBubble;
    logic             IfIdFlush;
    logic             PipeFreeze;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;
    logic             MemTimeout;

    int nChecks;
    int nPass;

    hazard_stall_ctrl #(
        .CNT_W    (CNT_W),
        .MAX_WAIT (MAX_WAIT)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .IfIdRs      (IfIdRs),
        .IfIdRt      (IfIdRt),
        .IfIdUsesRt  (IfIdUsesRt),
        .IdExMemRead (IdExMemRead),
        .IdExRt      (IdExRt),
        .BranchTaken (BranchTaken),
        .DMemBusy    (DMemBusy),
        .PcWrite     (PcWrite),
        .IfIdWrite   (IfIdWrite),
        .IdExBubble  (IdExBubble),
        .IfIdFlush   (IfIdFlush),
        .PipeFreeze  (PipeFreeze),
        .StallCount  (StallCount),
        .FlushCount  (FlushCount),
        .MemTimeout  (MemTimeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] enables();
        return 32'({PcWrite, IfIdWrite, IdExBubble, IfIdFlush, PipeFreeze});
    endfunction

    // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        IfIdRs      = 5'd0;
        IfIdRt      = 5'd0;
        IfIdUsesRt  = 1'b0;
        IdExMemRead = 1'b0;
        IdExRt      = 5'd0;
        BranchTaken = 1'b0;
        DMemBusy    = 1'b0;
    endtask

    initial begin
        nChecks = 0;
        nPass   = 0;
        rst     = 1'b1;
        idle_inputs();

        // Reset state
        next_cycle();
        check_val("rst_enables", enables(), 32'(C_RESET));
        check_val("rst_stall", 32'(StallCount), 32'd0);
        check_val("rst_flush", 32'(FlushCount), 32'd0);
        check_val("rst_timeout", 32'(MemTimeout), 32'd0);
        rst = 1'b0;
        settle();
        check_val("idle_enables", enables(), 32'(C_NORMAL));

        // Load-use on rs for one cycle
        IdExMemRead = 1'b1; IdExRt = 5'd8; IfIdRs = 5'd8;
        settle();
        check_val("lu_enables", enables(), 32'(C_BUBBLE));
        next_cycle();
        IdExMemRead = 1'b0;
        settle();
        check_val("lu_after_enables", enables(), 32'(C_NORMAL));
        check_val("lu_stall", 32'(StallCount), 32'd1);

        // $zero destination never stalls
        next_cycle();
        IdExMemRead = 1'b1; IdExRt = 5'd0; IfIdRs = 5'd0;
        settle();
        check_val("zero_enables", enables(), 32'(C_NORMAL));
        next_cycle();
        check_val("zero_stall", 32'(StallCount), 32'd1);

        // rt match only counts when the instruction reads rt
        IdExRt = 5'd9; IfIdRs = 5'd1; IfIdRt = 5'd9; IfIdUsesRt = 1'b0;
        settle();
        check_val("rt_unused_enables", enables(), 32'(C_NORMAL));
        IfIdUsesRt = 1'b1;
        settle();
        check_val("rt_used_enables", enables(), 32'(C_BUBBLE));
        next_cycle();
        check_val("rt_used_stall", 32'(StallCount), 32'd2);

        // Branch together with load-use: bubble wins, no flush
        BranchTaken = 1'b1;
        settle();
        check_val("br_lu_enables", enables(), 32'(C_BUBBLE));
        next_cycle();
        check_val("br_lu_flushcnt", 32'(FlushCount), 32'd0);
        check_val("br_lu_stall", 32'(StallCount), 32'd3);
        IdExMemRead = 1'b0; IfIdUsesRt = 1'b0;
        settle();
        check_val("br_enables", enables(), 32'(C_FLUSH));
        next_cycle();
        check_val("br_flushcnt", 32'(FlushCount), 32'd1);

        // Three busy cycles with a pending branch, then the branch flushes
        DMemBusy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check_val("busy_enables", enables(), 32'(C_FREEZE));
            next_cycle();
        end
        check_val("busy_stall", 32'(StallCount), 32'd6);
        check_val("busy_flushcnt", 32'(FlushCount), 32'd1);
        DMemBusy = 1'b0;
        settle();
        check_val("busy_end_enables", enables(), 32'(C_FLUSH));
        next_cycle();
        check_val("busy_end_flushcnt", 32'(FlushCount), 32'd2);
        BranchTaken = 1'b0;

        // Timeout: busy cycle MAX_WAIT+1 moves to ERROR on its edge
        DMemBusy = 1'b1;
        for (int i = 1; i <= MAX_WAIT + 1; i++) begin
            settle();
            check_val("to_enables", enables(), 32'(C_FREEZE));
            next_cycle();
            check_val("to_flag", 32'(MemTimeout), (i == MAX_WAIT + 1) ? 32'd1 : 32'd0);
        end
        check_val("to_stall", 32'(StallCount), 32'd11);
        DMemBusy = 1'b0; IdExMemRead = 1'b1; IdExRt = 5'd3; IfIdRs = 5'd3; BranchTaken = 1'b1;
        settle();
        check_val("err_enables", enables(), 32'(C_FREEZE));
        next_cycle();
        check_val("err_stall", 32'(StallCount), 32'd11);
        check_val("err_flushcnt", 32'(FlushCount), 32'd2);
        check_val("err_flag", 32'(MemTimeout), 32'd1);

        // Asynchronous reset mid-cycle clears everything at once
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_timeout", 32'(MemTimeout), 32'd0);
        check_val("arst_stall", 32'(StallCount), 32'd0);
        check_val("arst_flush", 32'(FlushCount), 32'd0);
        check_val("arst_enables", enables(), 32'(C_RESET));
        idle_inputs();
        rst = 1'b0;
        settle();
        check_val("arst_run_enables", enables(), 32'(C_NORMAL));

        // Saturation: 20 back-to-back load-use stalls on a 4-bit counter
        next_cycle();
        IdExMemRead = 1'b1; IdExRt = 5'd5; IfIdRs = 5'd5;
        for (int i = 1; i <= 20; i++) begin
            next_cycle();
            if (i == 15 || i == 20)
                check_val("sat_stall", 32'(StallCount), 32'd15);
        end
        check_val("sat_flushcnt", 32'(FlushCount), 32'd0);
        idle_inputs();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
